// File: rtl/icnbc_pkg.sv
// Shared defaults and FSM state encoding for the ICNBC distance filter.
package icnbc_pkg;

    localparam int unsigned ICNBC_N     = 8;
    localparam int unsigned ICNBC_DEPTH = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CMP,
        S_RES,
        S_DONE
    } state_t;

endpackage

// File: rtl/icnbc_hamming.sv
// Combinational Hamming distance: popcount(a ^ b).
module icnbc_hamming #(
    parameter  int unsigned N     = 8,
    localparam int unsigned OUT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     i_a,
    input  logic [N-1:0]     i_b,
    output logic [OUT_W-1:0] o_dist
);

    logic [N-1:0]     w_diff;
    logic [OUT_W-1:0] w_cnt;

    assign w_diff = i_a ^ i_b;

    // Count the differing bit positions.
    always_comb begin
        w_cnt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_cnt = w_cnt + OUT_W'(w_diff[i]);
        end
    end

    assign o_dist = w_cnt;

endmodule

// File: rtl/icnbc_dist_filter.sv
// Acceptance stage: stores a candidate only if it is at least min_ld away
// (Hamming) from every codeword accepted so far in the current run.
module icnbc_dist_filter
    import icnbc_pkg::*;
#(
    parameter  int unsigned N     = ICNBC_N,
    parameter  int unsigned DEPTH = ICNBC_DEPTH,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     min_ld,
    input  logic             cand_valid,
    output logic             cand_ready,
    input  logic [N-1:0]     cand_data,
    input  logic             cand_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_accept,
    output logic             res_full,
    output logic [N-1:0]     res_data,
    output logic [CNT_W-1:0] code_count,
    output logic             done,
    input  logic [CNT_W-1:0] rd_addr,
    output logic [N-1:0]     rd_data
);

    localparam int unsigned DIST_W = $clog2(N + 1);
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t           r_state;
    logic [N-1:0]     r_min_ld;
    logic [N-1:0]     r_cand;
    logic             r_last;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_count;
    logic             r_res_valid;
    logic             r_res_accept;
    logic             r_res_full;
    logic [N-1:0]     r_res_data;
    logic             r_done;
    logic [N-1:0]     r_rd_data;
    logic [N-1:0]     r_mem [DEPTH];

    logic [N-1:0]      w_cmp_word;
    logic [DIST_W-1:0] w_dist;
    logic              w_at_end;
    logic              w_full;
    logic              w_too_close;
    logic              w_wr_en;
    logic              w_rd_in_range;

    // The compared word is meaningless when r_idx == r_count; w_at_end takes
    // priority over the distance test in that cycle.
    assign w_cmp_word    = r_mem[r_idx[AW-1:0]];
    assign w_at_end      = (r_idx == r_count);
    assign w_full        = (r_count == CNT_W'(DEPTH));
    assign w_too_close   = (N'(w_dist) < r_min_ld);
    assign w_wr_en       = (r_state == S_CMP) && !start && w_at_end && !w_full;
    assign w_rd_in_range = (rd_addr < CNT_W'(DEPTH));

    icnbc_hamming #(.N(N)) u_hamming (
        .i_a    (r_cand),
        .i_b    (w_cmp_word),
        .o_dist (w_dist)
    );

    // Control FSM; start overrides every other event and aborts the run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_min_ld     <= '0;
            r_cand       <= '0;
            r_last       <= 1'b0;
            r_idx        <= '0;
            r_count      <= '0;
            r_res_valid  <= 1'b0;
            r_res_accept <= 1'b0;
            r_res_full   <= 1'b0;
            r_res_data   <= '0;
            r_done       <= 1'b0;
        end else if (start) begin
            r_state      <= S_WAIT;
            r_min_ld     <= min_ld;
            r_count      <= '0;
            r_done       <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_accept <= 1'b0;
            r_res_full   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_WAIT: begin
                    if (cand_valid) begin
                        r_cand  <= cand_data;
                        r_last  <= cand_last;
                        r_idx   <= '0;
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (w_at_end) begin
                        r_res_valid  <= 1'b1;
                        r_res_data   <= r_cand;
                        r_res_accept <= !w_full;
                        r_res_full   <= w_full;
                        if (!w_full) r_count <= r_count + 1'b1;
                        r_state      <= S_RES;
                    end else if (w_too_close) begin
                        r_res_valid  <= 1'b1;
                        r_res_data   <= r_cand;
                        r_res_accept <= 1'b0;
                        r_res_full   <= 1'b0;
                        r_state      <= S_RES;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_RES: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (r_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_DONE: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Codeword store write port; contents survive reset, code_count qualifies them.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_count[AW-1:0]] <= r_cand;
    end

    // Host read port, one cycle latency; a same-cycle write is not forwarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rd_data <= '0;
        else      r_rd_data <= w_rd_in_range ? r_mem[rd_addr[AW-1:0]] : '0;
    end

    assign cand_ready = (r_state == S_WAIT);
    assign res_valid  = r_res_valid;
    assign res_accept = r_res_accept;
    assign res_full   = r_res_full;
    assign res_data   = r_res_data;
    assign code_count = r_count;
    assign done       = r_done;
    assign rd_data    = r_rd_data;

endmodule

// File: tb/tb_icnbc_dist_filter.sv
// Self-checking bench for icnbc_dist_filter: a default-depth instance plus a
// DEPTH=4 instance sharing the same stimulus; "sel" picks the one observed.
module tb_icnbc_dist_filter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] min_ld = '0;
    logic       cand_valid = 1'b0;
    logic [7:0] cand_data = '0;
    logic       cand_last = 1'b0;
    logic       res_ready = 1'b0;
    logic [8:0] rd_addr = '0;
    logic       sel = 1'b0;

    logic       a_cand_ready, a_res_valid, a_res_accept, a_res_full, a_done;
    logic [7:0] a_res_data, a_rd_data;
    logic [8:0] a_code_count;
    logic       b_cand_ready, b_res_valid, b_res_accept, b_res_full, b_done;
    logic [7:0] b_res_data, b_rd_data;
    logic [2:0] b_code_count;

    logic       v_ready, v_res_valid, v_res_accept, v_res_full, v_done;
    logic [7:0] v_res_data, v_rd_data;
    logic [8:0] v_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_q[$];
    int         model_ml    = 0;
    int         model_depth = 256;

    always #5 clk = ~clk;

    icnbc_dist_filter #(.N(8), .DEPTH(256)) dut_a (
        .clk(clk), .rst(rst), .start(start), .min_ld(min_ld),
        .cand_valid(cand_valid), .cand_ready(a_cand_ready), .cand_data(cand_data),
        .cand_last(cand_last), .res_valid(a_res_valid), .res_ready(res_ready),
        .res_accept(a_res_accept), .res_full(a_res_full), .res_data(a_res_data),
        .code_count(a_code_count), .done(a_done), .rd_addr(rd_addr), .rd_data(a_rd_data)
    );

    icnbc_dist_filter #(.N(8), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .min_ld(min_ld),
        .cand_valid(cand_valid), .cand_ready(b_cand_ready), .cand_data(cand_data),
        .cand_last(cand_last), .res_valid(b_res_valid), .res_ready(res_ready),
        .res_accept(b_res_accept), .res_full(b_res_full), .res_data(b_res_data),
        .code_count(b_code_count), .done(b_done), .rd_addr(rd_addr[2:0]), .rd_data(b_rd_data)
    );

    assign v_ready      = sel ? b_cand_ready : a_cand_ready;
    assign v_res_valid  = sel ? b_res_valid  : a_res_valid;
    assign v_res_accept = sel ? b_res_accept : a_res_accept;
    assign v_res_full   = sel ? b_res_full   : a_res_full;
    assign v_res_data   = sel ? b_res_data   : a_res_data;
    assign v_done       = sel ? b_done       : a_done;
    assign v_rd_data    = sel ? b_rd_data    : a_rd_data;
    assign v_count      = sel ? {6'b0, b_code_count} : a_code_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: accept iff distance to every stored word >= min_ld and room left.
    // Latency = number of stored words examined (early exit on a close one) + 1.
    function automatic void model_cand(input logic [7:0] c, output bit acc, output bit full,
                                       output int lat);
        acc = 1'b0; full = 1'b0; lat = 0;
        foreach (model_q[i]) begin
            lat++;
            if ($countones(c ^ model_q[i]) < model_ml) return;
        end
        lat++;
        if (model_q.size() >= model_depth) full = 1'b1;
        else begin
            acc = 1'b1;
            model_q.push_back(c);
        end
    endfunction

    // All tasks enter and leave 1 time unit after a rising edge.
    task automatic do_start(input logic [7:0] ml, input int depth);
        @(posedge clk); #1;
        start = 1'b1; min_ld = ml;
        @(posedge clk); #1;
        start = 1'b0;
        model_q.delete(); model_ml = int'(ml); model_depth = depth;
    endtask

    task automatic handshake(input logic [7:0] d, input bit last, output bit ok);
        cand_valid = 1'b1; cand_data = d; cand_last = last;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (v_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin
            @(posedge clk); #1;
        end
        cand_valid = 1'b0;
        check("cand_ready_timeout", ok, 1);
    endtask

    task automatic send(input logic [7:0] d, input bit last, output int lat, output bit ok);
        bit got;
        handshake(d, last, ok);
        lat = 0; got = 1'b0;
        if (ok) begin
            for (int k = 0; k < 600; k++) begin
                @(posedge clk); #1;
                lat++;
                if (v_res_valid) begin got = 1'b1; break; end
            end
            check("res_valid_timeout", got, 1);
        end
        ok = ok && got;
    endtask

    task automatic res_hs();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic run_cand(input logic [7:0] d, input bit last);
        bit e_acc, e_full, ok;
        int e_lat, lat;
        model_cand(d, e_acc, e_full, e_lat);
        send(d, last, lat, ok);
        if (ok) begin
            check("rnd_accept", v_res_accept, e_acc);
            check("rnd_full", v_res_full, e_full);
            check("rnd_data", v_res_data, d);
            if (e_acc || e_full) check("rnd_latency", lat, e_lat);
            res_hs();
            check("rnd_count", v_count, model_q.size());
            if (last) check("rnd_done", v_done, 1);
        end
    endtask

    typedef struct {
        bit       sel;
        bit       do_st;
        bit [7:0] ml;
        bit [7:0] data;
        bit       last;
        bit       exp_acc;
        bit       exp_full;
        int       exp_cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit   ok;
        int   lat;
        int   mls[5];
        logic [7:0] d;

        // DEPTH=4 store fill, then the small-store run and a duplicate run.
        vecs.push_back('{1, 1, 8'd1, 8'h01, 0, 1, 0, 1});
        vecs.push_back('{1, 0, 8'd1, 8'h02, 0, 1, 0, 2});
        vecs.push_back('{1, 0, 8'd1, 8'h04, 0, 1, 0, 3});
        vecs.push_back('{1, 0, 8'd1, 8'h08, 0, 1, 0, 4});
        vecs.push_back('{1, 0, 8'd1, 8'h10, 1, 0, 1, 4});
        vecs.push_back('{0, 1, 8'd2, 8'h00, 0, 1, 0, 1});
        vecs.push_back('{0, 0, 8'd2, 8'h01, 0, 0, 0, 1});
        vecs.push_back('{0, 0, 8'd2, 8'h03, 1, 1, 0, 2});
        vecs.push_back('{0, 1, 8'd0, 8'hA5, 0, 1, 0, 1});
        vecs.push_back('{0, 0, 8'd0, 8'hA5, 0, 1, 0, 2});
        vecs.push_back('{0, 0, 8'd0, 8'hA5, 0, 1, 0, 3});
        vecs.push_back('{0, 0, 8'd0, 8'hA5, 0, 1, 0, 4});
        vecs.push_back('{0, 0, 8'd0, 8'hA5, 1, 1, 0, 5});

        // Reset state
        #12;
        check("rst_cand_ready", a_cand_ready, 0);
        check("rst_res_valid", a_res_valid, 0);
        check("rst_count", a_code_count, 0);
        check("rst_done", a_done, 0);
        check("rst_rd_data", a_rd_data, 0);
        check("rst_b_ready", b_cand_ready, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("idle_cand_ready", a_cand_ready, 0);

        // Table-driven vectors
        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            if (vecs[i].do_st) do_start(vecs[i].ml, sel ? 4 : 256);
            send(vecs[i].data, vecs[i].last, lat, ok);
            if (ok) begin
                check("vec_accept", v_res_accept, vecs[i].exp_acc);
                check("vec_full", v_res_full, vecs[i].exp_full);
                check("vec_data", v_res_data, vecs[i].data);
                if (vecs[i].exp_acc) check("vec_latency", lat, vecs[i].exp_cnt);
                if (vecs[i].exp_full) check("vec_full_latency", lat, vecs[i].exp_cnt + 1);
                res_hs();
                check("vec_count", v_count, vecs[i].exp_cnt);
                check("vec_done", v_done, vecs[i].last);
            end
        end
        sel = 1'b0;

        // Read back the five A5 words; address 4 first
        for (int a = 4; a >= 0; a--) begin
            rd_addr = 9'(a);
            @(posedge clk); #1;
            check("rd_a5", a_rd_data, 8'hA5);
        end

        // Write and read of address 0 in the same cycle returns the old word
        rd_addr = '0;
        do_start(8'd0, 256);
        send(8'h3C, 1'b1, lat, ok);
        check("rd_collision_old", a_rd_data, 8'hA5);
        @(posedge clk); #1;
        check("rd_collision_new", a_rd_data, 8'h3C);
        res_hs();

        // Back-pressure on the verdict
        do_start(8'd1, 256);
        send(8'h11, 1'b0, lat, ok);
        cand_valid = 1'b1; cand_data = 8'h22; cand_last = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("hold_res_valid", a_res_valid, 1);
            check("hold_res_data", a_res_data, 8'h11);
            check("hold_cand_ready", a_cand_ready, 0);
        end
        cand_valid = 1'b0;
        res_hs();
        check("hold_count", a_code_count, 1);

        // Abort during compare with three words stored
        send(8'h22, 1'b0, lat, ok); res_hs();
        send(8'h44, 1'b0, lat, ok); res_hs();
        check("abort_pre_count", a_code_count, 3);
        handshake(8'h88, 1'b0, ok);
        start = 1'b1; min_ld = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort_res_valid", a_res_valid, 0);
        check("abort_count", a_code_count, 0);
        check("abort_cand_ready", a_cand_ready, 1);
        send(8'h88, 1'b0, lat, ok);
        check("abort_next_accept", a_res_accept, 1);
        check("abort_next_latency", lat, 1);
        res_hs();
        check("abort_next_count", a_code_count, 1);

        // Asynchronous reset while a verdict is pending
        send(8'h55, 1'b0, lat, ok);
        check("pre_rst_res_valid", a_res_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_res_valid", a_res_valid, 0);
        check("arst_res_accept", a_res_accept, 0);
        check("arst_res_data", a_res_data, 0);
        check("arst_count", a_code_count, 0);
        check("arst_cand_ready", a_cand_ready, 0);
        check("arst_rd_data", a_rd_data, 0);
        @(negedge clk); rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        check("arst_idle_ready", a_cand_ready, 0);
        do_start(8'd1, 256);
        send(8'h66, 1'b1, lat, ok);
        check("arst_resume_accept", a_res_accept, 1);
        res_hs();
        check("arst_resume_done", a_done, 1);

        // Randomized runs against the reference model
        mls = '{0, 2, 3, 9, 1};
        foreach (mls[r]) begin
            int ncand;
            do_start(8'(mls[r]), 256);
            ncand = int'($urandom_range(12, 20));
            for (int c = 0; c < ncand; c++) begin
                if (model_q.size() > 0 && $urandom_range(0, 3) == 0)
                    d = model_q[$urandom_range(0, model_q.size() - 1)];
                else
                    d = 8'($urandom_range(0, 255));
                run_cand(d, c == ncand - 1);
            end
            foreach (model_q[i]) begin
                rd_addr = 9'(i);
                @(posedge clk); #1;
                check("rnd_readback", a_rd_data, model_q[i]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
